multi_switch_debouncer: RTL and testbench

Parametrised N-channel switch debouncer for the Spartan-6 board inputs, replacing the single-channel two-flop-and-AND debounce structure. Each channel synchronises its raw mechanical switch/button input and runs a per-channel stability counter. The debounced level changes only after the synchronised input has held its new value for STABLE_CYCLES consecutive clocks. The block sits directly behind the board pins and feeds clean levels plus one-cycle rise/fall strobes to downstream control logic.

---
 rtl/multi_switch_debouncer.sv | 77 +++++++
 tb/tb_multi_switch_debouncer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_switch_debouncer.sv
// N-channel switch debouncer: two-flop synchroniser, per-channel stability counter,
// registered debounced level and one-cycle rise/fall strobes.
module multi_switch_debouncer #(
  parameter int   N_CH          = 4,
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] sw_db,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic            any_change
);

  localparam int            CW      = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] s_q, s_d;
  logic [N_CH-1:0] db_q, db_d;
  logic [N_CH-1:0] rise_q, rise_d;
  logic [N_CH-1:0] fall_q, fall_d;
  logic            any_q, any_d;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];

  always_comb begin
    sync1_d = sw_in;
    s_d     = sync1_q;
    db_d    = db_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        // Strobes are registered alongside db so they coincide with the new level.
        db_d[i]   = s_q[i];
        cnt_d[i]  = '0;
        rise_d[i] = s_q[i];
        fall_d[i] = ~s_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    any_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= {N_CH{RESET_VAL}};
      s_q     <= {N_CH{RESET_VAL}};
      db_q    <= {N_CH{RESET_VAL}};
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      s_q     <= s_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sw_db      = db_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign any_change = any_q;

endmodule

// File: tb/tb_multi_switch_debouncer.sv
// Directed bench for multi_switch_debouncer; a window-based reference model pushes
// expected outputs per edge into a queue that is popped and compared after the edge.
module tb_multi_switch_debouncer;

  localparam int N = 4;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sw_in;
  logic [N-1:0] sw_db, rise_pulse, fall_pulse;
  logic         any_change;

  multi_switch_debouncer #(.N_CH(N), .STABLE_CYCLES(S), .RESET_VAL(1'b0)) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .sw_db(sw_db),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .any_change(any_change)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] db;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic         any;
  } exp_t;

  exp_t sb[$];
  int tests_run = 0;
  int failed    = 0;

  // Reference model: db flips when the last S synchronised samples all differ from it.
  logic [N-1:0] m_sync1, m_s, m_db, m_rise, m_fall;
  logic [S-1:0] m_hist [N];

  task automatic model_reset();
    m_sync1 = '0; m_s = '0; m_db = '0; m_rise = '0; m_fall = '0;
    for (int c = 0; c < N; c++) m_hist[c] = '0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.db = m_db; e.rise = m_rise; e.fall = m_fall; e.any = |(m_rise | m_fall);
    sb.push_back(e);
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      m_rise = '0; m_fall = '0;
      for (int c = 0; c < N; c++) begin
        m_hist[c] = {m_hist[c][S-2:0], m_s[c]};
        if (m_hist[c] == {S{~m_db[c]}}) begin
          m_db[c]   = ~m_db[c];
          m_rise[c] = m_db[c];
          m_fall[c] = ~m_db[c];
        end
      end
      m_s     = m_sync1;
      m_sync1 = sw_in;
    end
    push_exp();
  endtask

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
    tests_run++;
    assert (got === want) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b at %0t", name, got, want, $time);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      tests_run++; failed++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    chk("sw_db",      sw_db,      e.db);
    chk("rise_pulse", rise_pulse, e.rise);
    chk("fall_pulse", fall_pulse, e.fall);
    chk("any_change", {3'b000, any_change}, {3'b000, e.any});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    pop_compare();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Ticks n edges; lat = 1-based edge at which sw_db[ch] first equals lvl, or -1.
  task automatic measure(input int ch, input logic lvl, input int n, output int lat);
    lat = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (lat < 0 && sw_db[ch] === lvl) lat = i;
    end
  endtask

  int lat;
  int any_cnt;
  int both_seen;

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sw_in = '0;
    model_reset();
    ticks(2);
    sw_in = 4'b1111;
    ticks(8);
    rst = 1'b0;

    // Release reset with inputs high: all channels rise after qualification.
    measure(0, 1'b1, 10, lat);
    chk("lat_after_reset", lat[N-1:0], 4'd6);

    // Asynchronous reset in mid-cycle clears outputs without a clock edge.
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    push_exp();
    pop_compare();
    tick();
    rst = 1'b0;
    measure(0, 1'b1, 10, lat);
    chk("lat_rerelease", lat[N-1:0], 4'd6);

    sw_in = 4'b0000;
    ticks(10);

    // Clean press on channel 0.
    sw_in[0] = 1'b1;
    measure(0, 1'b1, 10, lat);
    chk("lat_press_ch0", lat[N-1:0], 4'd6);

    // Bounce on channel 1: 3-cycle high phases never qualify.
    for (int r = 0; r < 2; r++) begin
      sw_in[1] = 1'b1; ticks(3);
      sw_in[1] = 1'b0; ticks(3);
    end
    chk("bounce_no_db", sw_db, 4'b0001);
    sw_in[1] = 1'b1;
    measure(1, 1'b1, 10, lat);
    chk("lat_bounce_ch1", lat[N-1:0], 4'd6);

    // Release on channel 2.
    sw_in[2] = 1'b1;
    ticks(10);
    sw_in[2] = 1'b0;
    measure(2, 1'b0, 10, lat);
    chk("lat_release_ch2", lat[N-1:0], 4'd6);

    // Simultaneous rise on channel 0 and fall on channel 3.
    sw_in[3] = 1'b1;
    sw_in[0] = 1'b0;
    ticks(10);
    sw_in[0] = 1'b1;
    sw_in[3] = 1'b0;
    any_cnt = 0; both_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (any_change === 1'b1) any_cnt++;
      if (rise_pulse === 4'b0001 && fall_pulse === 4'b1000) both_seen++;
    end
    chk("simul_any_cycles", any_cnt[N-1:0], 4'd1);
    chk("simul_both_pulses", both_seen[N-1:0], 4'd1);

    // Reset in the middle of a count discards it.
    sw_in[0] = 1'b0;
    ticks(10);
    sw_in[0] = 1'b1;
    ticks(3);
    rst = 1'b1;
    model_reset();
    #1;
    push_exp();
    pop_compare();
    tick();
    rst = 1'b0;
    measure(0, 1'b1, 10, lat);
    chk("lat_reset_midcount", lat[N-1:0], 4'd6);
    ticks(4);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
